sobel_window_ctrl: RTL and testbench



---
 rtl/sobel_window_ctrl.sv | 168 ++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_ctrl.sv
// Streaming 3x3 Sobel window controller: two line buffers, |Gx|/|Gy| drive, registered magnitude out.
// Optional feature macro SOBEL_THRESH_EN binarises the output against THRESH.
module sobel_window_ctrl #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int THRESH = 128
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_pixel,
  output logic signed [10:0] gx,
  output logic signed [10:0] gy,
  input  logic [7:0]         g_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_pixel,
  output logic               busy,
  output logic               frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          ce;
  logic          accept;
  logic          last_pixel;
  logic          win_valid;
  logic [7:0]    lb0 [IMG_W];
  logic [7:0]    lb1 [IMG_W];
  logic [7:0]    win [3][3];
  logic [7:0]    pix_next;

  logic [11:0]   gx_pos, gx_neg, gy_pos, gy_neg;
  logic [11:0]   gx_diff, gy_diff;
  logic [10:0]   gx_abs, gy_abs;

  assign ce         = !out_valid || out_ready;
  assign in_ready   = (state == RUN) && ce;
  assign accept     = in_valid && in_ready;
  assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            row   <= '0;
            col   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            if (last_pixel) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!win_valid && !out_valid) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line buffers hold the two previous rows; rows 0-1 always rewrite them before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col] <= lb1[col];
      lb1[col] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win[i][j] <= 8'd0;
        end
      end
      win_valid <= 1'b0;
      out_valid <= 1'b0;
      out_pixel <= 8'd0;
    end else begin
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb0[col];
        win[1][2] <= lb1[col];
        win[2][2] <= in_pixel;
      end
      // Stalled windows stay flagged until the output register can take them.
      if (ce) begin
        win_valid <= accept && (row >= RW'(2)) && (col >= CW'(2));
        if (win_valid) begin
          out_valid <= 1'b1;
          out_pixel <= pix_next;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    gx_pos  = {4'd0, win[0][2]} + {3'd0, win[1][2], 1'b0} + {4'd0, win[2][2]};
    gx_neg  = {4'd0, win[0][0]} + {3'd0, win[1][0], 1'b0} + {4'd0, win[2][0]};
    gy_pos  = {4'd0, win[2][0]} + {3'd0, win[2][1], 1'b0} + {4'd0, win[2][2]};
    gy_neg  = {4'd0, win[0][0]} + {3'd0, win[0][1], 1'b0} + {4'd0, win[0][2]};
    gx_diff = gx_pos - gx_neg;
    gy_diff = gy_pos - gy_neg;
    // Magnitudes top out at 1020, so bit 11 of the negated value is always zero.
    gx_abs  = gx_diff[11] ? 11'(~gx_diff + 12'd1) : gx_diff[10:0];
    gy_abs  = gy_diff[11] ? 11'(~gy_diff + 12'd1) : gy_diff[10:0];
  end

  assign gx = $signed(gx_abs);
  assign gy = $signed(gy_abs);

`ifdef SOBEL_THRESH_EN
  localparam logic [7:0] THRESH_B = 8'(THRESH);
  assign pix_next = (g_in >= THRESH_B) ? 8'hFF : 8'h00;
`else
  assign pix_next = g_in;
`endif

  a_hold_stable: assert property (@(posedge clk) disable iff (!n_rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_pixel)));

  a_done_pulse: assert property (@(posedge clk) disable iff (!n_rst)
    frame_done |=> !frame_done);

  a_grad_nonneg: assert property (@(posedge clk) disable iff (!n_rst)
    (!gx[10] && !gy[10]));

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Randomised bench for sobel_window_ctrl: 4x4 and 5x5 instances checked against an image-level Sobel model.
module tb_sobel_window_ctrl;

  localparam int TH = 128;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  in_pixel;
  bit          sel;

  logic        ir4, ov4, busy4, fd4, ir5, ov5, busy5, fd5;
  logic [7:0]  op4, op5, g4, g5;
  logic [10:0] gx4, gy4, gx5, gy5;

  logic        in_ready, out_valid, busy, frame_done;
  logic [7:0]  out_pixel;
  logic [10:0] gx, gy;

  int vectors = 0;
  int errors  = 0;
  int img [0:4][0:4];
  int w = 4;
  int h = 4;
  int exp_q [$];

  always #5 clk = ~clk;

  // Downstream combiner: saturating |Gx| + |Gy|.
  function automatic logic [7:0] combine(input logic [10:0] a, input logic [10:0] b);
    int s;
    s = int'(a) + int'(b);
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  assign g4 = combine(gx4, gy4);
  assign g5 = combine(gx5, gy5);

  sobel_window_ctrl #(.IMG_W(4), .IMG_H(4), .THRESH(TH)) dut4 (
    .clk(clk), .n_rst(n_rst), .start(start && !sel), .in_valid(in_valid && !sel),
    .in_ready(ir4), .in_pixel(in_pixel), .gx(gx4), .gy(gy4), .g_in(g4),
    .out_valid(ov4), .out_ready(out_ready), .out_pixel(op4), .busy(busy4), .frame_done(fd4));

  sobel_window_ctrl #(.IMG_W(5), .IMG_H(5), .THRESH(TH)) dut5 (
    .clk(clk), .n_rst(n_rst), .start(start && sel), .in_valid(in_valid && sel),
    .in_ready(ir5), .in_pixel(in_pixel), .gx(gx5), .gy(gy5), .g_in(g5),
    .out_valid(ov5), .out_ready(out_ready), .out_pixel(op5), .busy(busy5), .frame_done(fd5));

  assign in_ready   = sel ? ir5   : ir4;
  assign out_valid  = sel ? ov5   : ov4;
  assign out_pixel  = sel ? op5   : op4;
  assign busy       = sel ? busy5 : busy4;
  assign frame_done = sel ? fd5   : fd4;
  assign gx         = sel ? gx5   : gx4;
  assign gy         = sel ? gy5   : gy4;

  // Reference model: Sobel gradient centred on image pixel (r,c).
  function automatic int grad(input bit is_x, input int r, input int c);
    int v;
    if (is_x)
      v = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
        - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    else
      v = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
        - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int expect_pix(input int r, input int c);
    int s;
    s = grad(1'b1, r, c) + grad(1'b0, r, c);
    if (s > 255) s = 255;
`ifdef SOBEL_THRESH_EN
    s = (s >= TH) ? 255 : 0;
`endif
    return s;
  endfunction

  task automatic select_dut(input bit s);
    sel = s;
    w   = s ? 5 : 4;
    h   = s ? 5 : 4;
  endtask

  task automatic fill_image(input int mode);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        case (mode)
          0:       img[r][c] = 50;
          1:       img[r][c] = (c < 2) ? 0 : 100;
          2:       img[r][c] = r * 10;
          3:       img[r][c] = r * 30;
          4:       img[r][c] = (r * 40 + c * 9) % 256;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
      end
    end
    exp_q.delete();
    for (int r = 1; r < h - 1; r++)
      for (int c = 1; c < w - 1; c++)
        exp_q.push_back(expect_pix(r, c));
  endtask

  // Drives one frame; bp_mode 0=ready high, 1=5-cycle stall, 2=random; iv_mode 0=continuous, 1=alternate, 2=random.
  task automatic run_frame(input int bp_mode, input int iv_mode, input bit start_mid, input int stop_after);
    int   idx, n_out, cyc, fd_cnt, last_hs, fd_at, total, wr, wc, r, c;
    bit   chk_win, hold, acc, hs;
    logic [7:0] held;
    idx = 0; n_out = 0; cyc = 0; fd_cnt = 0; last_hs = -100; fd_at = -1;
    total = w * h; wr = 0; wc = 0; chk_win = 0; hold = 0; held = 8'd0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      errors++; $display("[TB] FAIL busy_after_start: got %b want 1", busy);
    end
    while (cyc < 2000) begin
      if (chk_win) begin
        vectors += 2;
        if (gx !== 11'(grad(1'b1, wr, wc))) begin
          errors++; $display("[TB] FAIL gx at (%0d,%0d): got %0d want %0d", wr, wc, gx, grad(1'b1, wr, wc));
        end
        if (gy !== 11'(grad(1'b0, wr, wc))) begin
          errors++; $display("[TB] FAIL gy at (%0d,%0d): got %0d want %0d", wr, wc, gy, grad(1'b0, wr, wc));
        end
        chk_win = 0;
      end
      if (hold) begin
        vectors++;
        if (out_valid !== 1'b1 || out_pixel !== held) begin
          errors++; $display("[TB] FAIL hold: got valid=%b pix=%h want valid=1 pix=%h", out_valid, out_pixel, held);
        end
        hold = 0;
      end
      if (frame_done === 1'b1) begin
        fd_cnt++; fd_at = cyc;
      end
      if (fd_cnt > 0 && frame_done !== 1'b1) break;

      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(cyc >= 14 && cyc < 19);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      case (iv_mode)
        0:       in_valid = (idx < total);
        1:       in_valid = (idx < total) && (cyc % 2 == 0);
        default: in_valid = (idx < total) && ($urandom_range(0, 2) != 0);
      endcase
      in_pixel = (idx < total) ? 8'(img[idx / w][idx % w]) : 8'($urandom_range(0, 255));
      start    = start_mid && (cyc == 6);
      #1;
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (out_valid && !out_ready) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          errors++; $display("[TB] FAIL in_ready_stall: got %b want 0", in_ready);
        end
        hold = 1; held = out_pixel;
      end
      if (hs) begin
        vectors++;
        if (n_out >= exp_q.size()) begin
          errors++; $display("[TB] FAIL extra_output: got %h beyond %0d expected", out_pixel, exp_q.size());
        end else if (out_pixel !== 8'(exp_q[n_out])) begin
          errors++; $display("[TB] FAIL out_pixel #%0d: got %h want %h", n_out, out_pixel, 8'(exp_q[n_out]));
        end
        n_out++; last_hs = cyc;
      end
      if (acc) begin
        r = idx / w; c = idx % w;
        if (r >= 2 && c >= 2) begin
          chk_win = 1; wr = r - 1; wc = c - 1;
        end
        idx++;
      end
      @(posedge clk);
      cyc++;
      if (stop_after > 0 && idx == stop_after) return;
      @(negedge clk);
    end
    vectors += 6;
    if (cyc >= 2000) begin
      errors++; $display("[TB] FAIL timeout: got %0d cycles want < 2000", cyc);
    end
    if (n_out !== exp_q.size()) begin
      errors++; $display("[TB] FAIL output_count: got %0d want %0d", n_out, exp_q.size());
    end
    if (idx !== total) begin
      errors++; $display("[TB] FAIL accepted_count: got %0d want %0d", idx, total);
    end
    if (fd_cnt !== 1) begin
      errors++; $display("[TB] FAIL frame_done_pulses: got %0d want 1", fd_cnt);
    end
    if (fd_at !== last_hs + 2) begin
      errors++; $display("[TB] FAIL frame_done_timing: got cycle %0d want %0d", fd_at, last_hs + 2);
    end
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_after_frame: got busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      select_dut(s[0]);
      #1;
      vectors++;
      if ({in_ready, out_valid, out_pixel, busy, frame_done, gx, gy} !== 34'd0) begin
        errors++; $display("[TB] FAIL reset_values dut%0d: got %h want 0", s,
                           {in_ready, out_valid, out_pixel, busy, frame_done, gx, gy});
      end
    end
    @(negedge clk); n_rst = 1'b1;
  endtask

  task automatic test_constant;
    select_dut(1'b0); fill_image(0); run_frame(0, 0, 1'b0, 0);
  endtask

  task automatic test_columns;
    select_dut(1'b0); fill_image(1); run_frame(0, 0, 1'b0, 0);
  endtask

  task automatic test_rows;
    select_dut(1'b0); fill_image(2); run_frame(0, 0, 1'b0, 0);
    fill_image(3); run_frame(0, 0, 1'b0, 0);
  endtask

  task automatic test_backpressure;
    select_dut(1'b1); fill_image(4); run_frame(1, 0, 1'b0, 0);
  endtask

  task automatic test_reset_midframe;
    for (int s = 0; s < 2; s++) begin
      select_dut(s[0]);
      fill_image(5);
      run_frame(0, 0, 1'b0, (s == 0) ? 7 : 16);
      start = 1'b0; in_valid = 1'b0;
      #2 n_rst = 1'b0;
      #1;
      vectors++;
      if ({in_ready, out_valid, out_pixel, busy, frame_done, gx, gy} !== 34'd0) begin
        errors++; $display("[TB] FAIL midframe_reset dut%0d: got %h want 0", s,
                           {in_ready, out_valid, out_pixel, busy, frame_done, gx, gy});
      end
      @(negedge clk); n_rst = 1'b1;
      fill_image(5); run_frame(0, 0, 1'b0, 0);
    end
  endtask

  task automatic test_start_ignored;
    select_dut(1'b0); fill_image(5); run_frame(0, 0, 1'b1, 0);
    select_dut(1'b1); fill_image(5); run_frame(0, 0, 1'b1, 0);
  endtask

  task automatic test_valid_toggle;
    select_dut(1'b0); fill_image(2); run_frame(0, 1, 1'b0, 0);
    select_dut(1'b1); fill_image(4); run_frame(0, 1, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 8; k++) begin
      select_dut(k[0]);
      fill_image(5);
      run_frame(2, 2, 1'b0, 0);
    end
  endtask

  initial begin
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_pixel = 8'd0; sel = 1'b0;
    test_reset();
    test_constant();
    test_columns();
    test_rows();
    test_backpressure();
    test_reset_midframe();
    test_start_ignored();
    test_valid_toggle();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
